// File: rtl/vc_circular_buffer.sv
// rtl/vc_circular_buffer.sv - multi-VC circular flit buffer with per-VC full/empty and hysteresis on/off flow control
// Optional feature macro: VC_BUF_ERR_EN adds err_o with sticky per-VC overflow/underflow flags.
module vc_circular_buffer #(
    parameter int NUM_VC        = 4,
    parameter int BUFFER_SIZE   = 8,
    parameter int OFF_THRESHOLD = 6,
    parameter int ON_THRESHOLD  = 2,
    parameter int DATA_W        = 32,
    parameter int VC_W          = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CNT_W         = $clog2(BUFFER_SIZE) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_i,
    input  logic [VC_W-1:0]           write_vc_i,
    input  logic [DATA_W-1:0]         input_Data,
    input  logic                      read_i,
    input  logic [VC_W-1:0]           read_vc_i,
    output logic [DATA_W-1:0]         output_Data,
    output logic [NUM_VC-1:0]         buf_empty,
    output logic [NUM_VC-1:0]         buf_full,
    output logic [NUM_VC-1:0]         buf_On_Off,
    output logic [NUM_VC*CNT_W-1:0]   occupancy_o
`ifdef VC_BUF_ERR_EN
    ,
    output logic [2*NUM_VC-1:0]       err_o
`endif
);

    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

    localparam logic [VC_W:0]    NUM_VC_EXT = (VC_W+1)'(NUM_VC);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] OFF_CNT    = CNT_W'(OFF_THRESHOLD);
    localparam logic [CNT_W-1:0] ON_CNT     = CNT_W'(ON_THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    // Shared storage: one BUFFER_SIZE-deep ring per VC, never cleared by reset
    logic [DATA_W-1:0] mem_q [NUM_VC][BUFFER_SIZE];

    logic [PTR_W-1:0] wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0] wr_ptr_d [NUM_VC];
    logic [PTR_W-1:0] rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0] rd_ptr_d [NUM_VC];
    logic [CNT_W-1:0] count_q  [NUM_VC];
    logic [CNT_W-1:0] count_d  [NUM_VC];
    logic [NUM_VC-1:0] on_off_q;
    logic [NUM_VC-1:0] on_off_d;

    logic              wr_vc_ok;
    logic              rd_vc_ok;
    logic              wr_acc;
    logic              rd_acc;
    logic              same_vc;
    logic [NUM_VC-1:0] wr_sel;
    logic [NUM_VC-1:0] rd_sel;

    // Decide which of this cycle's requests are accepted
    always_comb begin
        wr_vc_ok = ({1'b0, write_vc_i} < NUM_VC_EXT);
        rd_vc_ok = ({1'b0, read_vc_i} < NUM_VC_EXT);
        same_vc  = (write_vc_i == read_vc_i);
        rd_acc   = 1'b0;
        wr_acc   = 1'b0;
        if (read_i && rd_vc_ok) begin
            rd_acc = (count_q[read_vc_i] != '0);
        end
        // A full VC still takes a write when its head is being popped in the same cycle
        if (write_i && wr_vc_ok) begin
            wr_acc = (count_q[write_vc_i] != FULL_CNT) || (rd_acc && same_vc);
        end
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel[v] = wr_acc && (write_vc_i == VC_W'(v));
            rd_sel[v] = rd_acc && (read_vc_i == VC_W'(v));
        end
    end

    // Per-VC next pointers, counts and hysteresis on/off state
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            count_d[v]  = count_q[v];
            on_off_d[v] = on_off_q[v];
            if (wr_sel[v]) begin
                wr_ptr_d[v] = wr_ptr_q[v] + PTR_ONE;
            end
            if (rd_sel[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + PTR_ONE;
            end
            if (wr_sel[v] && !rd_sel[v]) begin
                count_d[v] = count_q[v] + CNT_ONE;
            end else if (rd_sel[v] && !wr_sel[v]) begin
                count_d[v] = count_q[v] - CNT_ONE;
            end
            // Evaluated on the next count so the credit flips on the crossing edge
            if (count_d[v] >= OFF_CNT) begin
                on_off_d[v] = 1'b0;
            end else if (count_d[v] <= ON_CNT) begin
                on_off_d[v] = 1'b1;
            end
        end
    end

    // Pointer, count and credit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            on_off_q <= '1;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                count_q[v]  <= count_d[v];
            end
            on_off_q <= on_off_d;
        end
    end

    // Flit storage write; a write landing during reset is discarded
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[write_vc_i][wr_ptr_q[write_vc_i]] <= input_Data;
        end
    end

    // First-word fall-through head of the selected VC, zero when it holds nothing
    always_comb begin
        output_Data = '0;
        if (rd_vc_ok && (count_q[read_vc_i] != '0)) begin
            output_Data = mem_q[read_vc_i][rd_ptr_q[read_vc_i]];
        end
    end

    // Status flags and occupancy straight from the registered counts
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            buf_empty[v]                    = (count_q[v] == '0);
            buf_full[v]                     = (count_q[v] == FULL_CNT);
            occupancy_o[v*CNT_W +: CNT_W]   = count_q[v];
        end
        buf_On_Off = on_off_q;
    end

`ifdef VC_BUF_ERR_EN
    logic [2*NUM_VC-1:0] err_q;
    logic [2*NUM_VC-1:0] err_d;

    // Sticky flags: dropped writes in the low half, ignored reads in the high half
    always_comb begin
        err_d = err_q;
        for (int v = 0; v < NUM_VC; v++) begin
            if (write_i && wr_vc_ok && (write_vc_i == VC_W'(v)) && !wr_acc) begin
                err_d[v] = 1'b1;
            end
            if (read_i && rd_vc_ok && (read_vc_i == VC_W'(v)) && !rd_acc) begin
                err_d[NUM_VC+v] = 1'b1;
            end
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_vc_circular_buffer.sv
// tb/tb_vc_circular_buffer.sv - scoreboard bench for vc_circular_buffer
module tb_vc_circular_buffer;

    localparam int NV = 4;
    localparam int BS = 8;
    localparam int DW = 16;
    localparam int CW = 4;

    logic            clk;
    logic            rst;
    logic            write_i;
    logic [1:0]      write_vc_i;
    logic [DW-1:0]   input_Data;
    logic            read_i;
    logic [1:0]      read_vc_i;
    logic [DW-1:0]   output_Data;
    logic [NV-1:0]   buf_empty;
    logic [NV-1:0]   buf_full;
    logic [NV-1:0]   buf_On_Off;
    logic [NV*CW-1:0] occupancy_o;
`ifdef VC_BUF_ERR_EN
    logic [2*NV-1:0] err_o;
`endif

    vc_circular_buffer #(
        .NUM_VC(NV), .BUFFER_SIZE(BS), .OFF_THRESHOLD(6), .ON_THRESHOLD(2), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .write_i(write_i), .write_vc_i(write_vc_i), .input_Data(input_Data),
        .read_i(read_i), .read_vc_i(read_vc_i), .output_Data(output_Data),
        .buf_empty(buf_empty), .buf_full(buf_full), .buf_On_Off(buf_On_Off),
        .occupancy_o(occupancy_o)
`ifdef VC_BUF_ERR_EN
        , .err_o(err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    logic [DW-1:0] ref_q [NV][$];
    logic [DW-1:0] exp_q [$];
    logic [NV-1:0] on_model;
    logic [2*NV-1:0] err_model;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int v = 0; v < NV; v++) ref_q[v].delete();
        on_model  = '1;
        err_model = '0;
    endtask

    task automatic check_state();
        logic [NV*CW-1:0] occ;
        logic [NV-1:0] emp;
        logic [NV-1:0] ful;
        for (int v = 0; v < NV; v++) begin
            occ[v*CW +: CW] = CW'(ref_q[v].size());
            emp[v] = (ref_q[v].size() == 0);
            ful[v] = (ref_q[v].size() == BS);
        end
        check("occupancy", 64'(occupancy_o), 64'(occ));
        check("buf_empty", 64'(buf_empty), 64'(emp));
        check("buf_full", 64'(buf_full), 64'(ful));
        check("buf_On_Off", 64'(buf_On_Off), 64'(on_model));
`ifdef VC_BUF_ERR_EN
        check("err_o", 64'(err_o), 64'(err_model));
`endif
    endtask

    task automatic step(input bit w, input int wv, input logic [DW-1:0] d, input bit r, input int rv);
        bit rd_ok;
        bit wr_ok;
        int s;
        logic [DW-1:0] e;
        @(negedge clk);
        write_i    = w;
        write_vc_i = wv[1:0];
        input_Data = d;
        read_i     = r;
        read_vc_i  = rv[1:0];
        #1;
        if (ref_q[rv].size() > 0) exp_q.push_back(ref_q[rv][0]);
        else exp_q.push_back('0);
        e = exp_q.pop_front();
        check("output_Data", 64'(output_Data), 64'(e));
        rd_ok = r && (ref_q[rv].size() > 0);
        wr_ok = w && ((ref_q[wv].size() < BS) || (rd_ok && (rv == wv)));
        if (w && !wr_ok) err_model[wv] = 1'b1;
        if (r && !rd_ok) err_model[NV+rv] = 1'b1;
        @(posedge clk);
        if (rd_ok) void'(ref_q[rv].pop_front());
        if (wr_ok) ref_q[wv].push_back(d);
        for (int v = 0; v < NV; v++) begin
            s = ref_q[v].size();
            if (s >= 6) on_model[v] = 1'b0;
            else if (s <= 2) on_model[v] = 1'b1;
        end
        #1;
        check_state();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        write_i = 1'b0; write_vc_i = '0; input_Data = '0;
        read_i = 1'b0; read_vc_i = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        check("reset_out", 64'(output_Data), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // FIFO order on VC1
        step(1, 1, 16'h00A1, 0, 1);
        step(1, 1, 16'h00B2, 0, 1);
        step(1, 1, 16'h00C3, 0, 1);
        check("vc1_empty_vec", 64'(buf_empty), 64'hD);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1);
        step(0, 0, '0, 0, 1);

        // Fill VC0, overflow attempt, then drain
        for (int i = 0; i < 9; i++) step(1, 0, 16'h1000 + 16'(i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);

        // Full VC2 with simultaneous read and write
        for (int i = 0; i < 8; i++) step(1, 2, 16'h2000 + 16'(i), 0, 2);
        step(1, 2, 16'h2FFF, 1, 2);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 2);

        // Independent VCs in the same cycle
        step(1, 0, 16'h3001, 0, 0);
        step(1, 3, 16'h3333, 1, 0);

        // Read of empty VC2 with concurrent write: no bypass
        step(1, 2, 16'h4242, 1, 2);
        step(0, 0, '0, 0, 2);

        // Asynchronous reset mid-burst
        step(1, 1, 16'h5001, 0, 1);
        step(1, 1, 16'h5002, 0, 1);
        @(negedge clk);
        write_i = 1'b1; write_vc_i = 2'd1; input_Data = 16'h5003;
        read_i = 1'b0; read_vc_i = 2'd1;
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        check_state();
        check("async_rst_out", 64'(output_Data), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        write_i = 1'b0;
        #1;
        check_state();
        step(1, 1, 16'h6001, 0, 1);
        step(0, 0, '0, 1, 1);

        // Random traffic against the reference queues
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, NV-1)), DW'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NV-1)));
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_circular_buffer.md
Name: vc_circular_buffer

Overview:
Multi-virtual-channel successor to the single-queue circular buffer used at router input ports. It holds NUM_VC independent circular FIFOs, each BUFFER_SIZE flits deep, in one storage array. Each VC has its own full, empty and on/off flow-control status, and on/off uses hysteresis thresholds. It sits between the link receiver (write side) and the router's VC allocator / crossbar (read side).

Parameters:
NUM_VC, 4, number of virtual channels; must be >= 1.
BUFFER_SIZE, 8, flits per VC; power of 2, >= 2.
OFF_THRESHOLD, 6, occupancy at or above which buf_On_Off[v] drops; must satisfy ON_THRESHOLD < OFF_THRESHOLD <= BUFFER_SIZE.
ON_THRESHOLD, 2, occupancy at or below which buf_On_Off[v] rises again; must be >= 0.
VC_W, max(1,$clog2(NUM_VC)), derived; VC index width.
CNT_W, $clog2(BUFFER_SIZE)+1, derived; occupancy counter width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-high.
write_i  input  1  push input_Data into VC write_vc_i.
write_vc_i  input  VC_W  target VC for the write.
input_Data  input  flit_Data_noVC  flit to store.
read_i  input  1  pop the head of VC read_vc_i.
read_vc_i  input  VC_W  VC to read and to present on output_Data.
output_Data  output  flit_Data_noVC  head flit of VC read_vc_i.
buf_empty  output  NUM_VC  per-VC empty flag.
buf_full  output  NUM_VC  per-VC full flag.
buf_On_Off  output  NUM_VC  per-VC on/off credit to the upstream router; 1 = on.
occupancy_o  output  NUM_VC*CNT_W  per-VC flit count, VC v at bits [v*CNT_W +: CNT_W].

Behaviour:
- Reset (asynchronous, while rst=1):
  - all read/write pointers and counts = 0.
  - buf_empty = all 1s, buf_full = all 0s, buf_On_Off = all 1s, occupancy_o = 0.
  - output_Data = 0.
  - Storage contents are not cleared.
- Per-VC state: wr_ptr, rd_ptr (log2(BUFFER_SIZE) bits, wrap modulo BUFFER_SIZE) and count (CNT_W bits).
  - Storage address = vc*BUFFER_SIZE + ptr.
- Write:
  - Accepted when write_i=1 and (count[write_vc_i] < BUFFER_SIZE, or a read of the same VC is accepted in the same cycle).
  - Stores the flit at wr_ptr and increments wr_ptr.
  - A write to a full VC with no same-VC read is dropped; no state change.
- Read:
  - Accepted when read_i=1 and count[read_vc_i] > 0; increments rd_ptr.
  - A read of an empty VC is ignored, including when a same-VC write happens that cycle. There is no bypass.
- Output timing: first-word fall-through. output_Data is combinational mem[read_vc_i][rd_ptr] whenever that VC is non-empty, and 0 when it is empty.
  - A flit written at edge N is readable from edge N, i.e. visible after that edge.
- Count update per VC: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither.
  - Writes and reads on different VCs are fully independent in the same cycle.
- buf_empty[v] = (count==0) and buf_full[v] = (count==BUFFER_SIZE). Both are combinational from the registered counts.
- buf_On_Off[v] is registered with hysteresis, evaluated on next_count:
  - cleared when next_count >= OFF_THRESHOLD;
  - set when next_count <= ON_THRESHOLD;
  - otherwise held.
  - So it changes on the same edge the count crosses the threshold.
- VC select out of range (>= NUM_VC): the operation is ignored.
- Reset mid-operation: all VCs empty immediately. Writes in the reset cycle are lost.

Optional Feature:
VC_BUF_ERR_EN: adds output err_o [2*NUM_VC] with sticky per-VC flags, cleared only by rst.
- overflow[v] at bit v: set on a dropped write.
- underflow[v] at bit NUM_VC+v: set on an ignored read.
- Flags set on the edge after the offending request.
- Without the macro: the port does not exist and dropped/ignored operations are silent.

Test Plan:
- Reset, then write flits A,B,C to VC1 on consecutive cycles -> occupancy VC1=3, buf_empty=4'b1101; read VC1 three times -> output_Data A, B, C in order, then buf_empty[1]=1 and output_Data=0.
- Fill VC0 with 8 flits -> buf_full[0]=1, buf_On_Off[0]=0 from the 6th write edge; 9th write dropped, VC0 data intact; drain to 2 -> buf_On_Off[0]=1 on the edge count reaches 2.
- With VC2 full, simultaneous read+write VC2 -> count stays 8, head advances, new flit is returned as the 8th read after.
- Write VC3 while reading VC0 in the same cycle -> both accepted, VC3 count +1, VC0 count -1.
- Read empty VC2 together with write VC2 -> read ignored, count=1, output_Data shows the new flit next cycle; with VC_BUF_ERR_EN, err_o[NUM_VC+2]=1.
- Assert rst mid-burst -> outputs return to reset values asynchronously without waiting for clk; writes resume normally after rst falls. Also run 500 random read/write/VC ops checked against a per-VC reference queue, covering pointer wrap.
